// File: rtl/ir_dec_stage_if.sv
// ir_dec_stage_if: the fetch-side and execute-side handshake of the RV32I
// decode stage, bundled into one interface.
//   master: the environment. It drives in_valid/in_ir/in_pc/flush/out_ready.
//   slave : the decode stage. It drives in_ready, out_valid and the decoded fields.
// control_signals_t dw encoding: 00 = byte (DB), 01 = half (DH), 10 = word (DW).
// wb_src = 1 selects load data as the write-back source.

typedef struct packed {
    logic       w;
    logic       j;
    logic       b;
    logic       l;
    logic       s;
    logic [1:0] dw;
    logic       wb_src;
    logic       sign;
    logic       ignore_first_operand;
} control_signals_t;

interface ir_dec_stage_if #(
    parameter int IR_WIDTH = 32,
    parameter int XLEN     = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [IR_WIDTH-1:0] in_ir;
    logic [XLEN-1:0]     in_pc;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    control_signals_t    cs;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [2:0]          func3;
    logic [1:0]          alu_src_sel;
    logic [XLEN-1:0]     imm;
    logic                illegal;
    logic                fence;
    logic [1:0]          trap_cause;
    logic [XLEN-1:0]     dec_count;

    modport master (
        output in_valid, in_ir, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, cs, rs1, rs2, rd, func3,
               alu_src_sel, imm, illegal, fence, trap_cause, dec_count
    );

    modport slave (
        input  in_valid, in_ir, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, cs, rs1, rs2, rd, func3,
               alu_src_sel, imm, illegal, fence, trap_cause, dec_count
    );
endinterface

// File: rtl/ir_dec_stage.sv
// ir_dec_stage: registered RV32I decode stage between fetch and execute.
// The instruction is decoded combinationally and captured at input accept.
// A main entry drives the outputs. A skid entry holds one more instruction,
// so in_ready can come straight from a flop without losing throughput.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; takes priority over flush and
//          over the handshake
//   bus  - ir_dec_stage_if.slave, which carries:
//          in_* and in_ready on the fetch side,
//          out_*, out_ready and the decoded fields on the execute side,
//          flush,
//          dec_count (output transfers, wraps modulo 2^XLEN)

module ir_dec_stage #(
    parameter int IR_WIDTH = 32,
    parameter int XLEN     = 32,
    parameter bit EN_SYS   = 1'b1
) (
    input logic                clk,
    input logic                rst,
    ir_dec_stage_if.slave      bus
);

    if (IR_WIDTH != 32) begin : g_ir_width_check
        $error("ir_dec_stage: IR_WIDTH must be 32");
    end

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] SEL_RSB = 2'b00;
    localparam logic [1:0] SEL_I   = 2'b10;
    localparam logic [1:0] SEL_UJ  = 2'b11;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef struct packed {
        control_signals_t cs;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [2:0]       func3;
        logic [1:0]       alu_src_sel;
        logic [XLEN-1:0]  imm;
        logic             illegal;
        logic             fence;
        logic [1:0]       trap_cause;
        logic [XLEN-1:0]  pc;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [IR_WIDTH-1:0] ir;
    logic [6:0]          opcode;
    logic [2:0]          func3;
    logic [6:0]          func7;
    logic [XLEN-1:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
    logic                legal;
    entry_t              dec;

    assign ir     = bus.in_ir;
    assign opcode = ir[6:0];
    assign func3  = ir[14:12];
    assign func7  = ir[31:25];

    assign imm_i = XLEN'($signed(ir[31:20]));
    assign imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
    assign imm_b = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({ir[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));

    always_comb begin
        dec       = '0;
        legal     = 1'b0;
        dec.pc    = bus.in_pc;
        dec.rs1   = ir[19:15];
        dec.rs2   = ir[24:20];
        dec.rd    = ir[11:7];
        dec.func3 = func3;
        case (opcode)
            OPC_LUI: begin
                legal                       = 1'b1;
                dec.cs.w                    = 1'b1;
                dec.cs.ignore_first_operand = 1'b1;
                dec.alu_src_sel             = SEL_UJ;
                dec.imm                     = imm_u;
            end
            OPC_AUIPC: begin
                legal           = 1'b1;
                dec.cs.w        = 1'b1;
                dec.alu_src_sel = SEL_UJ;
                dec.imm         = imm_u;
            end
            OPC_JAL: begin
                legal           = 1'b1;
                dec.cs.w        = 1'b1;
                dec.cs.j        = 1'b1;
                dec.alu_src_sel = SEL_UJ;
                dec.imm         = imm_j;
            end
            OPC_JALR: begin
                legal           = (func3 == 3'b000);
                dec.cs.w        = 1'b1;
                dec.cs.j        = 1'b1;
                dec.alu_src_sel = SEL_I;
                dec.imm         = imm_i;
            end
            OPC_BRANCH: begin
                legal           = (func3 != 3'b010) && (func3 != 3'b011);
                dec.cs.b        = 1'b1;
                dec.alu_src_sel = SEL_RSB;
                dec.imm         = imm_b;
            end
            OPC_LOAD: begin
                // func3[1:0] is the access size and func3[2] means unsigned.
                legal           = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                dec.cs.l        = 1'b1;
                dec.cs.w        = 1'b1;
                dec.cs.wb_src   = 1'b1;
                dec.cs.sign     = !func3[2];
                dec.cs.dw       = func3[1:0];
                dec.alu_src_sel = SEL_I;
                dec.imm         = imm_i;
            end
            OPC_STORE: begin
                legal           = func3 inside {3'b000, 3'b001, 3'b010};
                dec.cs.s        = 1'b1;
                dec.cs.dw       = func3[1:0];
                dec.alu_src_sel = SEL_RSB;
                dec.imm         = imm_s;
            end
            OPC_OP_IMM: begin
                // Only the shift forms constrain func7, because it is the
                // upper part of the shamt field.
                if (func3 == 3'b001) begin
                    legal = (func7 == 7'b0);
                end else if (func3 == 3'b101) begin
                    legal = (func7 == 7'b0) || (func7 == F7_ALT);
                end else begin
                    legal = 1'b1;
                end
                dec.cs.w        = 1'b1;
                dec.alu_src_sel = SEL_I;
                dec.imm         = imm_i;
            end
            OPC_OP: begin
                legal = (func7 == 7'b0) ||
                        ((func7 == F7_ALT) && ((func3 == 3'b000) || (func3 == 3'b101)));
                dec.cs.w        = 1'b1;
                dec.cs.sign     = (func7 == F7_ALT) && (func3 == 3'b000);
                dec.alu_src_sel = SEL_RSB;
            end
            OPC_MISC_MEM: begin
                if (EN_SYS && (func3 == 3'b000)) begin
                    legal     = 1'b1;
                    dec.fence = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if (EN_SYS && (ir == 32'h0000_0073)) begin
                    legal          = 1'b1;
                    dec.trap_cause = 2'b01;
                end else if (EN_SYS && (ir == 32'h0010_0073)) begin
                    legal          = 1'b1;
                    dec.trap_cause = 2'b10;
                end
            end
            default: legal = 1'b0;
        endcase
        // Illegal words keep only their raw register and func3 fields.
        if (!legal) begin
            dec.cs          = '0;
            dec.imm         = '0;
            dec.alu_src_sel = SEL_RSB;
            dec.fence       = 1'b0;
            dec.illegal     = 1'b1;
            dec.trap_cause  = 2'b11;
        end
    end

    // ------------------------------------------------------------------
    // Two-entry skid FSM
    // ------------------------------------------------------------------
    state_t state_q, state_nx;
    logic   in_ready_q, out_valid_q;
    logic   accept, transfer;
    logic   load_main_in, load_main_skid, load_skid;
    entry_t main_q, skid_q;
    logic [XLEN-1:0] dec_count_q;

    assign accept   = bus.in_valid && in_ready_q;
    assign transfer = out_valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.flush) begin
            state_nx = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_nx     = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && transfer) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_nx  = TWO;
                        load_skid = 1'b1;
                    end else if (transfer) begin
                        state_nx = EMPTY;
                    end
                end
                TWO: begin
                    if (transfer) begin
                        state_nx       = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // The handshake flags have their own flops, so neither output depends
    // combinationally on the state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_nx != TWO);
            out_valid_q <= (state_nx != EMPTY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= dec;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    // A transfer in the flush cycle still happened, so it is still counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_count_q <= '0;
        end else if (transfer) begin
            dec_count_q <= dec_count_q + XLEN'(1);
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = main_q.pc;
    assign bus.cs          = main_q.cs;
    assign bus.rs1         = main_q.rs1;
    assign bus.rs2         = main_q.rs2;
    assign bus.rd          = main_q.rd;
    assign bus.func3       = main_q.func3;
    assign bus.alu_src_sel = main_q.alu_src_sel;
    assign bus.imm         = main_q.imm;
    assign bus.illegal     = main_q.illegal;
    assign bus.fence       = main_q.fence;
    assign bus.trap_cause  = main_q.trap_cause;
    assign bus.dec_count   = dec_count_q;

endmodule

// File: doc/ir_dec_stage.md
Name: ir_dec_stage

Overview:
Registered, parametrised RV32I decode stage with a valid/ready handshake on both sides. It sits between fetch and execute. It decodes the incoming instruction word into control_signals_t, register indices, immediate and ALU source select. It adds three things to decode: a 2-entry skid buffer, flush, and detection of illegal, FENCE, ECALL and EBREAK instructions. A retired-decode counter supports performance bring-up.

Parameters:
IR_WIDTH, 32, instruction word width; only 32 is supported, and an elaboration error is raised otherwise.
XLEN, 32, width of PC, immediate and counter.
EN_SYS, 1, 1 = decode FENCE/ECALL/EBREAK; 0 = the whole MISC-MEM/SYSTEM opcode space flags illegal.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept; registered
in_ir  in  IR_WIDTH  instruction word
in_pc  in  XLEN  PC of in_ir
flush  in  1  synchronous kill of all held entries
out_valid  out  1  decoded entry valid
out_ready  in  1  execute accepts the entry
out_pc  out  XLEN  PC of the decoded entry
cs  out  control_signals_t  w, j, b, l, s, dw, wb_src, sign, ignore_first_operand
rs1, rs2, rd  out  5 each  ir[19:15], ir[24:20], ir[11:7]
func3  out  3  ir[14:12]
alu_src_sel  out  2  R/S/B=00, I=10, U/J=11
imm  out  XLEN  sign-extended immediate per format
illegal  out  1  unsupported or malformed instruction
fence  out  1  FENCE decoded
trap_cause  out  2  00 none, 01 ECALL, 10 EBREAK, 11 illegal
dec_count  out  XLEN  count of entries transferred on the output

Behaviour:
- Handshake:
  - Input accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - Decode is combinational on in_ir and is captured into the entry at accept. Latency is 1 cycle from accept to out_valid.
  - Output fields are stable while out_valid && !out_ready.
- Storage: a main entry drives the outputs; a skid entry holds a second instruction. FIFO order is always preserved.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - TWO: out_valid=1, in_ready=0.
- Transitions:
  - EMPTY -> ONE on accept.
  - ONE -> TWO on accept without transfer.
  - ONE -> EMPTY on transfer without accept.
  - ONE stays ONE on accept together with transfer; the new entry loads main.
  - TWO -> ONE on transfer; the skid entry moves to main.
- Flush:
  - Any state goes to EMPTY next cycle.
  - Any input accepted in the flush cycle is discarded.
  - dec_count still counts a transfer that occurs in the flush cycle.
- Reset:
  - State EMPTY, in_ready=1, out_valid=0.
  - All decoded outputs 0, trap_cause 00, dec_count 0.
  - rst overrides flush and any handshake, including mid-operation.
- Decode rules:
  - LUI: w, ignore_first_operand, U.
  - AUIPC: w, U.
  - JAL: w, j, J.
  - JALR (func3=0): w, j, I.
  - Branches, func3 in {0,1,4,5,6,7}: b, B.
  - Loads: LB/LH/LW set l, w, wb_src, sign, with dw=DB/DH/DW. LBU/LHU are the same but sign=0.
  - SB/SH/SW: s, dw, S.
  - OP-IMM: w, I. SLLI requires func7=0; SRLI/SRAI require func7 of 0000000 or 0100000.
  - OP: w, R, with func7=0 for all; SUB and SRA require func7=0100000. SUB sets sign.
- Immediates:
  - I: sext ir[31:20].
  - S: sext {ir[31:25], ir[11:7]}.
  - B: sext {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - U: {ir[31:12], 12'b0}.
  - J: sext {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
- SYSTEM/MISC-MEM (EN_SYS=1):
  - ir==32'h00000073 gives trap_cause=01.
  - ir==32'h00100073 gives trap_cause=10.
  - opcode 0001111 with func3=0 gives fence=1.
  - In all three cases cs=0, imm=0, alu_src_sel=00.
  - Any other SYSTEM encoding (CSR) is illegal.
- Illegal: ir[1:0]!=11, unknown opcode, bad func3/func7 combination.
  - illegal=1 and trap_cause=11.
  - cs=0, imm=0, fence=0.
  - rs1/rs2/rd/func3 still reflect the raw fields.
  - The entry still flows through the handshake; it is never dropped.
- dec_count: +1 per output transfer, wraps modulo 2^XLEN.

Test Plan:
- Single decode, out_ready=1: in_ir=32'h12345537, in_pc=32'h100 -> next cycle out_valid=1, cs.w=1, cs.ignore_first_operand=1, rd=10, alu_src_sel=11, imm=32'h12345000, out_pc=32'h100, dec_count then increments to 1.
- Branch immediate: in_ir=32'hFE000EE3 (beq x0,x0,-4) -> cs.b=1, func3=0, alu_src_sel=00, imm=32'hFFFFFFFC, illegal=0.
- Backpressure: out_ready=0, offer ADDI/SUB/LW back-to-back -> first two accepted, in_ready=0 on cycle 3, outputs held steady. Raise out_ready -> ADDI, SUB (cs.sign=1), LW (cs.l=1, dw=DW, wb_src=1) emerge in order, dec_count=3.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, held and offered entries lost, dec_count unchanged.
- System and illegal cases:
  - 32'h00000073 -> trap_cause=01.
  - 32'h00100073 -> trap_cause=10.
  - 32'h0000000F -> fence=1.
  - 32'h00000000 -> illegal=1, trap_cause=11, cs=0.
  - SLLI with func7=0100000 -> illegal=1.
  - With EN_SYS=0, 32'h00000073 -> illegal=1.
- Reset mid-operation: assert rst for 1 cycle in TWO -> next cycle out_valid=0, in_ready=1, all decoded outputs 0, dec_count=0. The first post-reset instruction decodes normally.
